led_matrix_scan_ctrl: RTL and testbench

Scan controller and display scheduler for the 5×7 LED matrix. It generates the column scan and row drive from a clock prescaler. It also arbitrates between the two display requesters, AS (letter "A") and GT (letter "G"), and falls back to glyph "0" when neither is requesting. Each granted glyph is held for a minimum number of full frames, and glyph changes happen only on frame boundaries, so the matrix never shows a torn image.

---
 rtl/led_matrix_scan_ctrl_pkg.sv | 35 +++
 rtl/led_matrix_scan_ctrl_if.sv | 15 +
 rtl/led_matrix_scan_ctrl_glyph_rom.sv | 21 ++
 rtl/led_matrix_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_led_matrix_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_scan_ctrl_pkg.sv
// Shared types and glyph bitmaps for the 5x7 LED matrix scan controller.
// Bitmaps are indexed [column], bit n of each entry drives row n+1.
package led_matrix_pkg;

  localparam int unsigned NCOLS = 5;
  localparam int unsigned NROWS = 7;

  typedef enum logic [1:0] {
    GL_ZERO = 2'b00,
    GL_A    = 2'b01,
    GL_G    = 2'b10
  } glyph_e;

  typedef enum logic [1:0] {
    IDLE,
    SHOW_A,
    SHOW_G
  } arb_state_e;

  typedef logic [NROWS-1:0] bitmap_t [NCOLS];

  localparam bitmap_t GLYPH_ZERO = '{7'b0011100, 7'b0111110, 7'b1000001, 7'b0111110, 7'b0011100};
  localparam bitmap_t GLYPH_A    = '{7'b1111100, 7'b1101110, 7'b0010011, 7'b1101110, 7'b1111100};
  localparam bitmap_t GLYPH_G    = '{7'b0011100, 7'b0111110, 7'b1001001, 7'b1111001, 7'b0111010};

  function automatic logic [NCOLS-1:0] col_onehot(input logic [2:0] col);
    logic [NCOLS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NCOLS; i++) begin
      if (col == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// Display-side signal bundle: enable/requests in, column/row drive and status out.
interface led_matrix_scan_ctrl_if;
  import led_matrix_pkg::*;

  logic             EN;
  logic             AS;
  logic             GT;
  logic [NCOLS-1:0] C;
  logic [NROWS-1:0] L;
  logic [1:0]       GLYPH;
  logic             FRAME_DONE;

  modport master (output EN, AS, GT, input C, L, GLYPH, FRAME_DONE);
  modport slave  (input EN, AS, GT, output C, L, GLYPH, FRAME_DONE);
endinterface

// File: rtl/led_matrix_scan_ctrl_glyph_rom.sv
// Combinational glyph bitmap lookup: (glyph, column) -> 7-bit row pattern.
module glyph_rom
  import led_matrix_pkg::*;
(
  input  glyph_e           glyph,
  input  logic [2:0]       col,
  output logic [NROWS-1:0] rows
);

  always_comb begin
    rows = '0;
    if (col < 3'(NCOLS)) begin
      case (glyph)
        GL_A:    rows = GLYPH_A[col];
        GL_G:    rows = GLYPH_G[col];
        default: rows = GLYPH_ZERO[col];
      endcase
    end
  end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// 5x7 LED matrix column scanner with frame-aligned round-robin glyph scheduling
// between the A and G requesters, falling back to "0" when idle.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned HOLD_FRAMES = 50
) (
  input logic             CLK,
  input logic             RST_N,
  led_matrix_scan_ctrl_if.slave disp
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic             as_s1, as_s, gt_s1, gt_s;
  logic [PW-1:0]    pre;
  logic [2:0]       col;
  logic             tick, frame_end;
  logic [HW-1:0]    hold, hold_n;
  arb_state_e       state, state_n;
  glyph_e           last, last_n, grant, cur_glyph;
  logic [NROWS-1:0] rom_rows;
  logic [NCOLS-1:0] c_q;
  logic [NROWS-1:0] l_q;
  logic             fd_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      as_s1 <= 1'b0;
      as_s  <= 1'b0;
      gt_s1 <= 1'b0;
      gt_s  <= 1'b0;
    end else begin
      as_s1 <= disp.AS;
      as_s  <= as_s1;
      gt_s1 <= disp.GT;
      gt_s  <= gt_s1;
    end
  end

  assign tick      = (pre == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (col == 3'd4);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre <= '0;
      col <= '0;
    end else if (!disp.EN) begin
      pre <= '0;
      col <= '0;
    end else if (tick) begin
      pre <= '0;
      col <= (col == 3'd4) ? 3'd0 : col + 3'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      hold  <= '0;
      last  <= GL_G;
    end else if (!disp.EN) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      last  <= last_n;
    end
  end

  // Decisions only on frame boundaries; an unfinished hold wins over any request change.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    last_n  = last;
    grant   = GL_ZERO;
    if (frame_end) begin
      if (state != IDLE && hold < HW'(HOLD_FRAMES - 1)) begin
        hold_n = hold + HW'(1);
      end else begin
        if (as_s && gt_s)  grant = (last == GL_A) ? GL_G : GL_A;
        else if (as_s)     grant = GL_A;
        else if (gt_s)     grant = GL_G;
        case (grant)
          GL_A: begin
            state_n = SHOW_A;
            hold_n  = '0;
            last_n  = GL_A;
          end
          GL_G: begin
            state_n = SHOW_G;
            hold_n  = '0;
            last_n  = GL_G;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (state)
      SHOW_A:  cur_glyph = GL_A;
      SHOW_G:  cur_glyph = GL_G;
      default: cur_glyph = GL_ZERO;
    endcase
  end

  glyph_rom u_rom (
    .glyph(cur_glyph),
    .col  (col),
    .rows (rom_rows)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_q  <= '0;
      l_q  <= '0;
      fd_q <= 1'b0;
    end else begin
      c_q  <= disp.EN ? col_onehot(col) : '0;
      l_q  <= disp.EN ? rom_rows : '0;
      fd_q <= disp.EN && frame_end;
    end
  end

  assign disp.C          = c_q;
  assign disp.L          = l_q;
  assign disp.GLYPH      = cur_glyph;
  assign disp.FRAME_DONE = fd_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Randomized/directed bench for led_matrix_scan_ctrl against a frame-level reference model.
module tb_led_matrix_scan_ctrl;

  localparam int SD    = 4;
  localparam int HF    = 2;
  localparam int FRAME = SD * 5;

  localparam logic [6:0] TZ [5] = '{7'b0011100, 7'b0111110, 7'b1000001, 7'b0111110, 7'b0011100};
  localparam logic [6:0] TA [5] = '{7'b1111100, 7'b1101110, 7'b0010011, 7'b1101110, 7'b1111100};
  localparam logic [6:0] TG [5] = '{7'b0011100, 7'b0111110, 7'b1001001, 7'b1111001, 7'b0111010};

  logic CLK = 1'b0;
  logic RST_N;
  int   passed = 0;
  int   total  = 0;

  led_matrix_scan_ctrl_if disp ();

  led_matrix_scan_ctrl #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .disp (disp)
  );

  always #5 CLK = ~CLK;

  // Reference model: enabled-cycle count t gives column and frame position directly.
  int         t      = 0;
  int         m_rem  = 0;
  logic [1:0] m_glyph = 2'd0;
  logic [1:0] m_last  = 2'd2;
  logic       ar1 = 1'b0, ar2 = 1'b0, gr1 = 1'b0, gr2 = 1'b0;
  logic [4:0] exp_c  = '0;
  logic [6:0] exp_l  = '0;
  logic       exp_fd = 1'b0;

  function automatic logic [6:0] bm(input logic [1:0] g, input int c);
    if (g == 2'd1) return TA[c];
    if (g == 2'd2) return TG[c];
    return TZ[c];
  endfunction

  always @(posedge CLK or negedge RST_N) begin : model
    int         col;
    bit         fe;
    logic [1:0] g;
    if (!RST_N) begin
      t <= 0; m_rem <= 0; m_glyph <= 2'd0; m_last <= 2'd2;
      ar1 <= 1'b0; ar2 <= 1'b0; gr1 <= 1'b0; gr2 <= 1'b0;
      exp_c <= '0; exp_l <= '0; exp_fd <= 1'b0;
    end else begin
      col = (t / SD) % 5;
      fe  = disp.EN && (t % FRAME == FRAME - 1);
      exp_c  <= disp.EN ? 5'(1 << col) : 5'd0;
      exp_l  <= disp.EN ? bm(m_glyph, col) : 7'd0;
      exp_fd <= fe;
      ar1 <= disp.AS; ar2 <= ar1;
      gr1 <= disp.GT; gr2 <= gr1;
      if (!disp.EN) begin
        t <= 0;
        m_glyph <= 2'd0;
      end else begin
        t <= t + 1;
        if (fe) begin
          if (m_glyph != 2'd0 && m_rem > 1) m_rem <= m_rem - 1;
          else begin
            if (ar2 && gr2)  g = (m_last == 2'd1) ? 2'd2 : 2'd1;
            else if (ar2)    g = 2'd1;
            else if (gr2)    g = 2'd2;
            else             g = 2'd0;
            m_glyph <= g;
            if (g != 2'd0) begin
              m_rem  <= HF;
              m_last <= g;
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    RST_N = 1'b0; disp.EN = 1'b0; disp.AS = 1'b0; disp.GT = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== 15'd0)
      $display("FAIL reset: C/L/GLYPH/FD got %b_%b_%b_%b want all zero", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE);
    else passed++;
    RST_N = 1'b1; disp.EN = 1'b1;
    @(negedge CLK);
    total++;
    if (disp.C !== 5'b00001) $display("FAIL first_col: C got %b want 00001", disp.C);
    else passed++;
  endtask

  task automatic test_scan_idle();
    repeat (60) begin
      @(negedge CLK);
      total++;
      if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== {exp_c, exp_l, m_glyph, exp_fd})
        $display("FAIL scan_idle: got %b_%b_%b_%b want %b_%b_%b_%b", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE, exp_c, exp_l, m_glyph, exp_fd);
      else passed++;
      if (disp.C == 5'b00010) begin
        total++;
        if (disp.L !== 7'b0111110) $display("FAIL zero_col2: L got %b want 0111110", disp.L);
        else passed++;
      end
    end
  endtask

  task automatic test_single_a();
    repeat (8) @(negedge CLK);
    disp.AS = 1'b1;
    repeat (80) begin
      @(negedge CLK);
      total++;
      if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== {exp_c, exp_l, m_glyph, exp_fd})
        $display("FAIL single_a: got %b_%b_%b_%b want %b_%b_%b_%b", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE, exp_c, exp_l, m_glyph, exp_fd);
      else passed++;
      if (disp.C == 5'b00010 && disp.GLYPH == 2'b01) begin
        total++;
        if (disp.L !== 7'b1101110) $display("FAIL a_col2: L got %b want 1101110", disp.L);
        else passed++;
      end
    end
    total++;
    if (disp.GLYPH !== 2'b01) $display("FAIL a_held: GLYPH got %b want 01", disp.GLYPH);
    else passed++;
  endtask

  task automatic test_round_robin();
    int changes = 0;
    logic [1:0] prev;
    disp.AS = 1'b1; disp.GT = 1'b1;
    prev = disp.GLYPH;
    repeat (240) begin
      @(negedge CLK);
      total++;
      if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== {exp_c, exp_l, m_glyph, exp_fd})
        $display("FAIL round_robin: got %b_%b_%b_%b want %b_%b_%b_%b", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE, exp_c, exp_l, m_glyph, exp_fd);
      else passed++;
      if (disp.GLYPH != prev) changes++;
      prev = disp.GLYPH;
    end
    total++;
    if (changes < 4) $display("FAIL rr_changes: glyph changes got %0d want >= 4", changes);
    else passed++;
  endtask

  task automatic test_short_gt();
    int g_cycles = 0;
    int waited   = 0;
    disp.AS = 1'b0; disp.GT = 1'b0;
    repeat (80) begin
      @(negedge CLK);
      total++;
      if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== {exp_c, exp_l, m_glyph, exp_fd})
        $display("FAIL short_gt_idle: got %b_%b_%b_%b want %b_%b_%b_%b", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE, exp_c, exp_l, m_glyph, exp_fd);
      else passed++;
    end
    while (t % FRAME != FRAME - 4 && waited < FRAME) begin
      @(negedge CLK);
      waited++;
    end
    disp.GT = 1'b1;
    repeat (3) @(negedge CLK);
    disp.GT = 1'b0;
    repeat (100) begin
      @(negedge CLK);
      total++;
      if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== {exp_c, exp_l, m_glyph, exp_fd})
        $display("FAIL short_gt: got %b_%b_%b_%b want %b_%b_%b_%b", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE, exp_c, exp_l, m_glyph, exp_fd);
      else passed++;
      if (disp.GLYPH == 2'b10) g_cycles++;
    end
    total++;
    if (g_cycles != HF * FRAME) $display("FAIL short_gt_len: G cycles got %0d want %0d", g_cycles, HF * FRAME);
    else passed++;
    total++;
    if (disp.GLYPH !== 2'b00) $display("FAIL short_gt_end: GLYPH got %b want 00", disp.GLYPH);
    else passed++;
  endtask

  task automatic test_en_low();
    int waited = 0;
    disp.AS = 1'b1;
    repeat (60) @(negedge CLK);
    total++;
    if (disp.GLYPH !== 2'b01) $display("FAIL en_pre: GLYPH got %b want 01", disp.GLYPH);
    else passed++;
    while (t % FRAME != 8 && waited < FRAME) begin
      @(negedge CLK);
      waited++;
    end
    disp.EN = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      total++;
      if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== 15'd0)
        $display("FAIL en_low: got %b_%b_%b_%b want all zero", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE);
      else passed++;
    end
    disp.EN = 1'b1;
    @(negedge CLK);
    total++;
    if (disp.C !== 5'b00001) $display("FAIL en_restart: C got %b want 00001", disp.C);
    else passed++;
    repeat (40) begin
      @(negedge CLK);
      total++;
      if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== {exp_c, exp_l, m_glyph, exp_fd})
        $display("FAIL en_resume: got %b_%b_%b_%b want %b_%b_%b_%b", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE, exp_c, exp_l, m_glyph, exp_fd);
      else passed++;
    end
    total++;
    if (disp.GLYPH !== 2'b01) $display("FAIL en_regrant: GLYPH got %b want 01", disp.GLYPH);
    else passed++;
  endtask

  task automatic test_reset_mid();
    disp.AS = 1'b0; disp.GT = 1'b1;
    repeat (80) @(negedge CLK);
    total++;
    if (disp.GLYPH !== 2'b10) $display("FAIL rst_pre: GLYPH got %b want 10", disp.GLYPH);
    else passed++;
    repeat (7) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    total++;
    if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== 15'd0)
      $display("FAIL rst_mid: got %b_%b_%b_%b want all zero", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE);
    else passed++;
    @(negedge CLK);
    RST_N = 1'b1; disp.GT = 1'b0;
    @(negedge CLK);
    total++;
    if ({disp.C, disp.GLYPH} !== {5'b00001, 2'b00}) $display("FAIL rst_restart: C/GLYPH got %b_%b want 00001_00", disp.C, disp.GLYPH);
    else passed++;
    repeat (30) begin
      @(negedge CLK);
      total++;
      if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== {exp_c, exp_l, m_glyph, exp_fd})
        $display("FAIL rst_resume: got %b_%b_%b_%b want %b_%b_%b_%b", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE, exp_c, exp_l, m_glyph, exp_fd);
      else passed++;
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      @(negedge CLK);
      total++;
      if ({disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE} !== {exp_c, exp_l, m_glyph, exp_fd})
        $display("FAIL random: got %b_%b_%b_%b want %b_%b_%b_%b", disp.C, disp.L, disp.GLYPH, disp.FRAME_DONE, exp_c, exp_l, m_glyph, exp_fd);
      else passed++;
      if ($urandom_range(0, 29) == 0)  disp.AS = ~disp.AS;
      if ($urandom_range(0, 29) == 0)  disp.GT = ~disp.GT;
      if ($urandom_range(0, 149) == 0) disp.EN = ~disp.EN;
    end
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_single_a();
    test_round_robin();
    test_short_gt();
    test_en_low();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
